// File: rtl/exception_commit.sv
// Registered multi-slot exception/ERET commit unit.
// Picks the oldest faulting slot, strobes CP0 once, flushes, then redirects fetch.
module exception_commit #(
    parameter int          ISSUE_WIDTH  = 2,
    parameter int          INT_W        = 8,
    parameter int          FLUSH_CYCLES = 2,
    parameter logic [31:0] EXC_VECTOR   = 32'hbfc00380
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      pipe_stall,
    input  logic [ISSUE_WIDTH-1:0]    slot_valid,
    input  logic [32*ISSUE_WIDTH-1:0] slot_pc,
    input  logic [ISSUE_WIDTH-1:0]    slot_in_delay,
    input  logic [ISSUE_WIDTH-1:0]    slot_exc_valid,
    input  logic [5*ISSUE_WIDTH-1:0]  slot_exc_code,
    input  logic [32*ISSUE_WIDTH-1:0] slot_bad_vaddr,
    input  logic [ISSUE_WIDTH-1:0]    slot_bad_vaddr_valid,
    input  logic [ISSUE_WIDTH-1:0]    slot_eret,
    input  logic                      allow_interrupt,
    input  logic [INT_W-1:0]          int_pending,
    input  logic [31:0]               epc_in,
    output logic [ISSUE_WIDTH-1:0]    commit_mask,
    output logic                      busy,
    output logic                      cp0_exp_en,
    output logic                      cp0_exl_clean,
    output logic [31:0]               cp0_exp_epc,
    output logic [4:0]                cp0_exp_code,
    output logic                      cp0_exp_bd,
    output logic [31:0]               cp0_exp_bad_vaddr,
    output logic                      cp0_exp_bad_vaddr_wen,
    output logic                      flush,
    output logic                      redirect_valid,
    output logic [31:0]               redirect_pc
);

    localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    typedef enum logic {
        IDLE,
        FLUSH
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          int_req_q, int_req_d;
    logic          exp_en_q, exp_en_d;
    logic          exl_clean_q, exl_clean_d;
    logic [31:0]   epc_q, epc_d;
    logic [4:0]    code_q, code_d;
    logic          bd_q, bd_d;
    logic [31:0]   bva_q, bva_d;
    logic          bva_wen_q, bva_wen_d;
    logic [31:0]   target_q, target_d;

    logic          accept;
    logic          found;
    logic          seen_valid;
    logic          is_lowest;
    int            win_idx;
    logic          sel_eret;
    logic [4:0]    sel_code;
    logic [31:0]   sel_pc;
    logic          sel_bd;
    logic [31:0]   sel_bva;
    logic          sel_bva_wen;
    logic          evt;

    assign accept = (state_q == IDLE) && !pipe_stall;

    // Oldest slot with an interrupt, exception or ERET wins.
    always_comb begin
        found       = 1'b0;
        seen_valid  = 1'b0;
        is_lowest   = 1'b0;
        win_idx     = 0;
        sel_eret    = 1'b0;
        sel_code    = '0;
        sel_pc      = '0;
        sel_bd      = 1'b0;
        sel_bva     = '0;
        sel_bva_wen = 1'b0;
        for (int k = 0; k < ISSUE_WIDTH; k++) begin
            is_lowest = slot_valid[k] && !seen_valid;
            if (slot_valid[k]) seen_valid = 1'b1;
            if (!found && slot_valid[k]) begin
                if ((is_lowest && int_req_q) || slot_exc_valid[k]
                    || slot_eret[k]) begin
                    found       = 1'b1;
                    win_idx     = k;
                    sel_pc      = slot_pc[32*k +: 32];
                    sel_bd      = slot_in_delay[k];
                    sel_bva     = slot_bad_vaddr[32*k +: 32];
                    sel_bva_wen = slot_bad_vaddr_valid[k];
                    if (is_lowest && int_req_q) begin
                        sel_code = 5'd0;
                    end else if (slot_exc_valid[k]) begin
                        sel_code = slot_exc_code[5*k +: 5];
                    end else begin
                        sel_eret = 1'b1;
                    end
                end
            end
        end
    end

    assign evt = accept && found;

    always_comb begin
        commit_mask = '0;
        if (accept) begin
            for (int k = 0; k < ISSUE_WIDTH; k++) begin
                if (found) begin
                    commit_mask[k] = (k < win_idx) || (k == win_idx && sel_eret);
                end else begin
                    commit_mask[k] = slot_valid[k];
                end
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        int_req_d   = allow_interrupt & (|int_pending);
        exp_en_d    = 1'b0;
        exl_clean_d = 1'b0;
        bva_wen_d   = 1'b0;
        epc_d       = epc_q;
        code_d      = code_q;
        bd_d        = bd_q;
        bva_d       = bva_q;
        target_d    = target_q;
        case (state_q)
            IDLE: begin
                if (evt) begin
                    state_d = FLUSH;
                    cnt_d   = CW'(FLUSH_CYCLES - 1);
                    if (sel_eret) begin
                        exl_clean_d = 1'b1;
                        target_d    = epc_in;
                    end else begin
                        exp_en_d  = 1'b1;
                        epc_d     = sel_bd ? sel_pc - 32'd4 : sel_pc;
                        code_d    = sel_code;
                        bd_d      = sel_bd;
                        bva_d     = sel_bva;
                        bva_wen_d = sel_bva_wen;
                        target_d  = EXC_VECTOR;
                    end
                end
            end
            FLUSH: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            int_req_q   <= 1'b0;
            exp_en_q    <= 1'b0;
            exl_clean_q <= 1'b0;
            epc_q       <= '0;
            code_q      <= '0;
            bd_q        <= 1'b0;
            bva_q       <= '0;
            bva_wen_q   <= 1'b0;
            target_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            int_req_q   <= int_req_d;
            exp_en_q    <= exp_en_d;
            exl_clean_q <= exl_clean_d;
            epc_q       <= epc_d;
            code_q      <= code_d;
            bd_q        <= bd_d;
            bva_q       <= bva_d;
            bva_wen_q   <= bva_wen_d;
            target_q    <= target_d;
        end
    end

    assign busy                  = (state_q != IDLE);
    assign flush                 = (state_q == FLUSH);
    assign redirect_valid        = (state_q == FLUSH) && (cnt_q == '0);
    assign redirect_pc           = target_q;
    assign cp0_exp_en            = exp_en_q;
    assign cp0_exl_clean         = exl_clean_q;
    assign cp0_exp_epc           = epc_q;
    assign cp0_exp_code          = code_q;
    assign cp0_exp_bd            = bd_q;
    assign cp0_exp_bad_vaddr     = bva_q;
    assign cp0_exp_bad_vaddr_wen = bva_wen_q;

endmodule

// File: doc/exception_commit.md
Name: exception_commit

Overview:
- Multi-issue, registered exception/ERET commit unit; parametrised successor of the single-slot combinational exception resolver.
- Sits at the commit boundary (after MEM) and receives pre-decoded exception status for up to ISSUE_WIDTH in-order slots.
- Picks the oldest faulting slot and produces a commit mask. Issues a one-cycle CP0 update, then sequences a multi-cycle pipeline flush ending in a PC redirect.

Parameters:
ISSUE_WIDTH, 2, number of in-order commit slots; slot 0 is oldest
INT_W, 8, interrupt-pending vector width
FLUSH_CYCLES, 2, cycles flush is held high (>=1)
EXC_VECTOR, 32'hbfc00380, general exception entry PC

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
pipe_stall  input  1  commit stage stalled; no event accepted
slot_valid  input  ISSUE_WIDTH  slot holds a real instruction
slot_pc  input  32*ISSUE_WIDTH  slot PC, slot k at [32k+31:32k]
slot_in_delay  input  ISSUE_WIDTH  slot is a branch delay-slot instruction
slot_exc_valid  input  ISSUE_WIDTH  slot raised a synchronous exception
slot_exc_code  input  5*ISSUE_WIDTH  ExcCode for that exception
slot_bad_vaddr  input  32*ISSUE_WIDTH  faulting address
slot_bad_vaddr_valid  input  ISSUE_WIDTH  BadVAddr must be written
slot_eret  input  ISSUE_WIDTH  slot is ERET
allow_interrupt  input  1  Status.IE & ~EXL
int_pending  input  INT_W  masked Cause.IP
epc_in  input  32  current CP0 EPC (ERET target)
commit_mask  output  ISSUE_WIDTH  combinational; slots allowed to retire this cycle
busy  output  1  FSM not IDLE
cp0_exp_en  output  1  one-cycle CP0 exception write strobe
cp0_exl_clean  output  1  one-cycle EXL clear strobe (ERET)
cp0_exp_epc  output  32  EPC value
cp0_exp_code  output  5  ExcCode
cp0_exp_bd  output  1  Cause.BD
cp0_exp_bad_vaddr  output  32  BadVAddr value
cp0_exp_bad_vaddr_wen  output  1  BadVAddr write strobe
flush  output  1  pipeline flush
redirect_valid  output  1  one-cycle fetch redirect
redirect_pc  output  32  redirect target

Behaviour:
- Reset: state IDLE, int_req_q=0, all registered outputs 0. Reset mid-flush aborts with no redirect.
- int_req_q <= allow_interrupt & (|int_pending) every cycle. Interrupt requests are therefore seen one cycle late. They are level-held, so a request raised while busy is taken after return to IDLE.
- Event candidates are evaluated in IDLE when !pipe_stall. Per slot k, a candidate exists if slot_valid[k] and one of the following holds, in priority order:
  - (k is the lowest valid slot and int_req_q): code 0
  - slot_exc_valid[k]: slot_exc_code[k]
  - slot_eret[k]
- Across slots, the lowest index with a candidate wins. Slots without an event are ignored.
- commit_mask, when an event is selected: bits below the winner are set. The winner's bit is set only for ERET. Younger slots are cleared.
- commit_mask with no event: equals slot_valid.
- commit_mask when busy or pipe_stall: 0.
- EPC/BD for an exception or interrupt at slot k: bd=slot_in_delay[k]; epc = in_delay ? pc-4 : pc, modulo 2^32.
- Cycle T = event cycle. At T+1, registered outputs are driven for exactly one cycle:
  - Exception/interrupt: cp0_exp_en=1; epc/code/bd from the selected slot; cp0_exp_bad_vaddr_wen=slot_bad_vaddr_valid[k]; cp0_exp_bad_vaddr=slot_bad_vaddr[k].
  - ERET: cp0_exl_clean=1, cp0_exp_en=0, target=epc_in sampled at T.
  - All other strobes are 0. The cp0 data outputs hold their values until the next event.
- FSM states:
  - IDLE: event -> FLUSH, counter=FLUSH_CYCLES-1.
  - FLUSH: flush=1. If counter==0 -> REDIRECT-exit: redirect_valid=1, redirect_pc=target (EXC_VECTOR or latched epc), then IDLE. Otherwise decrement.
- Resulting timing: flush is high during T+1..T+FLUSH_CYCLES. redirect_valid is high in cycle T+FLUSH_CYCLES. busy=1 over the same window. A new event is accepted no earlier than T+FLUSH_CYCLES+1.
- Slot inputs are ignored while busy.

Test Plan:
- ISSUE_WIDTH=2, slot0 pc=0x80000100, exc code 0x08, not delay: commit_mask=00 at T. At T+1: cp0_exp_en=1, epc=0x80000100, bd=0, code=8. flush high T+1..T+2. redirect_valid at T+2 with pc 0xbfc00380.
- slot0 branch at 0x80000200, slot1 in_delay with code 0x0c: commit_mask=01, epc=0x80000200, bd=1.
- slot0 bad-vaddr code 0x04 with slot_bad_vaddr=0x80001001, and slot1 code 0x0a in the same cycle: slot0 wins. cp0_exp_bad_vaddr_wen=1 with 0x80001001. commit_mask=00.
- ERET in slot0, epc_in=0x80003000: commit_mask=01, cp0_exl_clean=1 at T+1, cp0_exp_en=0, redirect_pc=0x80003000.
- int_pending=0x04 raised with allow_interrupt=1 while busy: no action until IDLE. Then code 0 is taken on slot0, overriding slot0 exc code 0x08.
- rst asserted at T+1 of an event: flush=0 and redirect_valid=0 next cycle, busy=0, no later redirect.
